// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin bus arbiter with wait-state tracking and a
// timeout abort for slaves that never return ready.
module bus_rr_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rest,
    input  logic       bus_m0_req,
    input  logic       bus_m1_req,
    input  logic       bus_m2_req,
    input  logic       bus_m3_req,
    input  logic       bus_m0_as,
    input  logic       bus_m1_as,
    input  logic       bus_m2_as,
    input  logic       bus_m3_as,
    input  logic       bus_rdy,
    output logic       bus_m0_grnt,
    output logic       bus_m1_grnt,
    output logic       bus_m2_grnt,
    output logic       bus_m3_grnt,
    output logic [1:0] bus_owner,
    output logic       bus_owner_vld,
    output logic       bus_busy,
    output logic       bus_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_last_owner;
    logic [7:0] r_cnt;
    logic [3:0] r_grnt;
    logic [1:0] r_owner;
    logic       r_vld;
    logic       r_busy;
    logic       r_tmo;

    logic [3:0] w_req;
    logic [3:0] w_as;
    logic       w_any_req;
    logic       w_own_req;
    logic       w_own_as;
    logic       w_tmo_hit;
    logic       w_found;
    logic [1:0] w_winner;
    logic [1:0] w_idx;

    assign w_req     = {bus_m3_req, bus_m2_req, bus_m1_req, bus_m0_req};
    assign w_as      = {bus_m3_as, bus_m2_as, bus_m1_as, bus_m0_as};
    assign w_any_req = |w_req;
    assign w_own_req = w_req[r_owner];
    assign w_own_as  = w_as[r_owner];
    assign w_tmo_hit = (r_cnt == (TIMEOUT - 8'd1));

    // Scan starts one past the last winner so every master gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_owner;
        w_idx    = r_last_owner;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_owner + k[1:0];
            if (!w_found && w_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            r_state      <= S_IDLE;
            r_last_owner <= 2'd3;
            r_cnt        <= 8'd0;
            r_grnt       <= 4'd0;
            r_owner      <= 2'd0;
            r_vld        <= 1'b0;
            r_busy       <= 1'b0;
            r_tmo        <= 1'b0;
        end else begin
            r_tmo <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= S_OWNED;
                        r_grnt       <= 4'd1 << w_winner;
                        r_owner      <= w_winner;
                        r_vld        <= 1'b1;
                        r_last_owner <= w_winner;
                    end else begin
                        r_grnt  <= 4'd0;
                        r_owner <= 2'd0;
                        r_vld   <= 1'b0;
                    end
                end
                S_OWNED: begin
                    if (!w_own_req) begin
                        r_state <= S_IDLE;
                        r_grnt  <= 4'd0;
                        r_owner <= 2'd0;
                        r_vld   <= 1'b0;
                    end else if (w_own_as && !bus_rdy) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // A late ready still completes the access.
                    if (bus_rdy) begin
                        r_state <= S_OWNED;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b0;
                        r_tmo   <= 1'b1;
                        r_grnt  <= 4'd0;
                        r_owner <= 2'd0;
                        r_vld   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grnt  <= 4'd0;
                    r_owner <= 2'd0;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_m0_grnt   = r_grnt[0];
    assign bus_m1_grnt   = r_grnt[1];
    assign bus_m2_grnt   = r_grnt[2];
    assign bus_m3_grnt   = r_grnt[3];
    assign bus_owner     = r_owner;
    assign bus_owner_vld = r_vld;
    assign bus_busy      = r_busy;
    assign bus_timeout   = r_tmo;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level arbitration model.
module tb_bus_rr_arbiter;

    localparam int TO = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] as_v;
    logic       rdy;
    logic       g0, g1, g2, g3;
    logic [1:0] owner;
    logic       vld;
    logic       busy;
    logic       tmo;

    int n_vec;
    int n_err;

    int m_owner;
    int m_last;
    int m_waited;
    bit m_wait;
    bit m_tmo;

    wire [3:0] w_grnt = {g3, g2, g1, g0};
    wire [8:0] w_dut  = {g3, g2, g1, g0, owner, vld, busy, tmo};

    bus_rr_arbiter #(.TIMEOUT(8'(TO))) u_dut (
        .clk           (clk),
        .rest          (rst),
        .bus_m0_req    (req[0]),
        .bus_m1_req    (req[1]),
        .bus_m2_req    (req[2]),
        .bus_m3_req    (req[3]),
        .bus_m0_as     (as_v[0]),
        .bus_m1_as     (as_v[1]),
        .bus_m2_as     (as_v[2]),
        .bus_m3_as     (as_v[3]),
        .bus_rdy       (rdy),
        .bus_m0_grnt   (g0),
        .bus_m1_grnt   (g1),
        .bus_m2_grnt   (g2),
        .bus_m3_grnt   (g3),
        .bus_owner     (owner),
        .bus_owner_vld (vld),
        .bus_busy      (busy),
        .bus_timeout   (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    // Who owns the bus, whether the owner is stalled, how long it has
    // stalled, and who won last.
    task automatic model_step(input logic [3:0] rq, input logic [3:0] av,
                              input logic rd, input logic rs);
        int idx;
        bit found;
        m_tmo = 1'b0;
        if (rs) begin
            m_owner  = -1;
            m_last   = 3;
            m_wait   = 1'b0;
            m_waited = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (!found && rq[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                end
            end
            if (found) m_last = m_owner;
        end else if (m_wait) begin
            if (rd) begin
                m_wait = 1'b0;
            end else if (m_waited == TO - 1) begin
                m_wait  = 1'b0;
                m_owner = -1;
                m_tmo   = 1'b1;
            end else begin
                m_waited++;
            end
        end else if (!rq[m_owner]) begin
            m_owner = -1;
        end else if (av[m_owner] && !rd) begin
            m_wait   = 1'b1;
            m_waited = 0;
        end
    endtask

    function automatic logic [8:0] mdl_vec();
        logic [3:0] g;
        logic [1:0] o;
        g = (m_owner >= 0) ? (4'd1 << m_owner) : 4'd0;
        o = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        return {g, o, (m_owner >= 0), m_wait, m_tmo};
    endfunction

    task automatic step(input logic [3:0] rq, input logic [3:0] av,
                        input logic rd, input logic rs);
        req  = rq;
        as_v = av;
        rdy  = rd;
        rst  = rs;
        model_step(rq, av, rd, rs);
        @(negedge clk);
        chk("model", {7'd0, w_dut}, {7'd0, mdl_vec()});
    endtask

    initial begin
        logic [3:0] rq;
        logic [3:0] av;
        n_vec = 0;
        n_err = 0;
        m_owner = -1;
        m_last = 3;
        m_wait = 1'b0;
        m_waited = 0;
        m_tmo = 1'b0;
        req = 4'd0;
        as_v = 4'd0;
        rdy = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // reset with requests pending must not grant
        step(4'b1111, 4'd0, 1'b0, 1'b1);
        step(4'b1111, 4'd0, 1'b1, 1'b1);
        chk("reset_out", {7'd0, w_dut}, 16'd0);
        step(4'b0000, 4'd0, 1'b1, 1'b0);
        chk("idle_rdy", {7'd0, w_dut}, 16'd0);

        // lone m2 request
        step(4'b0100, 4'd0, 1'b0, 1'b0);
        chk("m2_grant", {9'd0, w_grnt, owner, vld},
            {9'd0, 4'b0100, 2'd2, 1'b1});
        step(4'b0000, 4'd0, 1'b0, 1'b0);
        chk("m2_release", {12'd0, w_grnt}, 16'd0);

        // m0 access times out, m1 waits behind it
        step(4'b0001, 4'd0, 1'b0, 1'b0);
        step(4'b0011, 4'b0001, 1'b0, 1'b0);
        chk("busy_t1", {15'd0, busy}, 16'd1);
        for (int i = 0; i < 3; i++) step(4'b0011, 4'd0, 1'b0, 1'b0);
        chk("busy_t4", {12'd0, w_grnt}, {12'd0, 4'b0001});
        step(4'b0011, 4'd0, 1'b0, 1'b0);
        chk("tmo_pulse", {13'd0, tmo, busy, vld}, {13'd0, 3'b100});
        step(4'b0011, 4'd0, 1'b0, 1'b0);
        chk("after_tmo", {11'd0, tmo, w_grnt}, {11'd0, 1'b0, 4'b0010});

        // ready on the final wait cycle beats the timeout
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 4'd0, 1'b0, 1'b0);
        step(4'b0000, 4'd0, 1'b1, 1'b0);
        chk("rdy_wins", {10'd0, tmo, busy, w_grnt},
            {10'd0, 2'b00, 4'b0010});
        step(4'b0000, 4'd0, 1'b0, 1'b0);
        chk("rdy_release", {12'd0, w_grnt}, 16'd0);

        // reset in the middle of an m3 wait
        step(4'b1000, 4'd0, 1'b0, 1'b0);
        step(4'b1111, 4'b1000, 1'b0, 1'b0);
        chk("m3_wait", {11'd0, busy, w_grnt}, {11'd0, 1'b1, 4'b1000});
        step(4'b1111, 4'b1111, 1'b0, 1'b1);
        chk("rst_midwait", {7'd0, w_dut}, 16'd0);
        step(4'b1111, 4'd0, 1'b0, 1'b0);
        chk("first_m0", {12'd0, w_grnt}, {12'd0, 4'b0001});

        // rotation m0 -> m1 -> m2 -> m3 -> m0 with idle gaps
        step(4'b1110, 4'd0, 1'b0, 1'b0);
        chk("gap0", {12'd0, w_grnt}, 16'd0);
        step(4'b1110, 4'd0, 1'b0, 1'b0);
        chk("rot_m1", {12'd0, w_grnt}, {12'd0, 4'b0010});
        step(4'b1100, 4'd0, 1'b0, 1'b0);
        step(4'b1100, 4'd0, 1'b0, 1'b0);
        chk("rot_m2", {12'd0, w_grnt}, {12'd0, 4'b0100});
        step(4'b1000, 4'd0, 1'b0, 1'b0);
        step(4'b1000, 4'd0, 1'b0, 1'b0);
        chk("rot_m3", {12'd0, w_grnt}, {12'd0, 4'b1000});
        step(4'b0111, 4'd0, 1'b0, 1'b0);
        chk("gap3", {12'd0, w_grnt}, 16'd0);
        step(4'b0111, 4'd0, 1'b0, 1'b0);
        chk("rot_m0", {12'd0, w_grnt}, {12'd0, 4'b0001});

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rq = 4'($urandom | $urandom);
            av = 4'($urandom);
            step(rq, av, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        step(4'd0, 4'd0, 1'b0, 1'b1);
        chk("final_rst", {7'd0, w_dut}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
